// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an 18-bit LED register behind a valid/ready request/response port.
// Latency: accept-to-rsp_valid is 1 cycle, or WAIT_CYCLES+1 cycles when DMEM_WAIT_EN is defined (and WAIT_CYCLES > 0).
// Backpressure: one outstanding request; req_ready only in IDLE, and the response is held until rsp_ready.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [17:0] led_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_WAIT_EN
  localparam bit USE_WAIT = (WAIT_CYCLES > 0);
  localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [17:0] led_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  // Request being committed: live inputs when committing on the accept edge, captured copy otherwise.
  logic        cm_we;
  logic [31:0] cm_addr;
  logic [31:0] cm_wdata;
  logic [3:0]  cm_be;
  logic        commit;

`ifdef DMEM_WAIT_EN
  logic [CW-1:0] cnt_q;
  logic          cap_we_q;
  logic [31:0]   cap_addr_q;
  logic [31:0]   cap_wdata_q;
  logic [3:0]    cap_be_q;

  // Select the committing request and detect the edge that moves into RESP.
  always_comb begin
    cm_we    = cap_we_q;
    cm_addr  = cap_addr_q;
    cm_wdata = cap_wdata_q;
    cm_be    = cap_be_q;
    if (state_q == S_IDLE) begin
      cm_we    = req_we;
      cm_addr  = req_addr;
      cm_wdata = req_wdata;
      cm_be    = req_be;
    end
    commit = ((state_q == S_IDLE) && req_valid && !USE_WAIT) ||
             ((state_q == S_WAIT) && (cnt_q == '0));
  end
`else
  // Without wait states every accepted request commits on its accept edge.
  always_comb begin
    cm_we    = req_we;
    cm_addr  = req_addr;
    cm_wdata = req_wdata;
    cm_be    = req_be;
    commit   = (state_q == S_IDLE) && req_valid;
  end
`endif

  logic          be_ok;
  logic          ram_hit;
  logic          led_hit;
  logic          err_d;
  logic [AW-1:0] idx;
  logic [31:0]   rdata_d;
  logic [17:0]   led_d;
  logic          ram_wr;

  // Decode the committing request: lane legality, target, response word and LED next value.
  always_comb begin
    case (cm_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
    ram_hit = (cm_addr < 32'(DEPTH_WORDS * 4));
    led_hit = !ram_hit && (cm_addr[31:2] == LED_ADDR[31:2]);
    err_d   = !be_ok || !(ram_hit || led_hit);
    idx     = cm_addr[AW+1:2];
    rdata_d = 32'h0;
    if (!err_d && !cm_we) begin
      rdata_d = ram_hit ? mem_q[idx] : {14'b0, led_q};
    end
    led_d = led_q;
    if (!err_d && cm_we && led_hit) begin
      if (cm_be[0]) led_d[7:0]   = cm_wdata[7:0];
      if (cm_be[1]) led_d[15:8]  = cm_wdata[15:8];
      if (cm_be[2]) led_d[17:16] = cm_wdata[17:16];
    end
    ram_wr = commit && !err_d && cm_we && ram_hit;
  end

  // Byte-lane RAM write on the commit edge; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      if (cm_be[0]) mem_q[idx][7:0]   <= cm_wdata[7:0];
      if (cm_be[1]) mem_q[idx][15:8]  <= cm_wdata[15:8];
      if (cm_be[2]) mem_q[idx][23:16] <= cm_wdata[23:16];
      if (cm_be[3]) mem_q[idx][31:24] <= cm_wdata[31:24];
    end
  end

  // Request/response sequencer with registered handshake outputs, response and LED register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      led_q       <= 18'h0;
`ifdef DMEM_WAIT_EN
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
      cap_be_q    <= 4'h0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
`ifdef DMEM_WAIT_EN
            cap_we_q    <= req_we;
            cap_addr_q  <= req_addr;
            cap_wdata_q <= req_wdata;
            cap_be_q    <= req_be;
`endif
            if (commit) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= err_d;
              led_q       <= led_d;
            end else begin
`ifdef DMEM_WAIT_EN
              state_q <= S_WAIT;
              cnt_q   <= CW'(WAIT_CYCLES - 1);
`endif
            end
          end
        end
`ifdef DMEM_WAIT_EN
        S_WAIT: begin
          if (commit) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            led_q       <= led_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed transactions, a spec-level memory/LED model and a per-cycle compare process.
module tb_dmem_responder;

`ifdef DMEM_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [17:0] led_out;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: word array, LED register, and expected port view.
  logic [31:0] mm [256];
  logic [17:0] exp_led   = 18'h0;
  logic        exp_busy  = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err   = 1'b0;
  logic        run_chk   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the spec rules for one committed request to the model.
  task automatic model_commit(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be);
    logic legal, ram, led;
    legal = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
            (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
    ram   = (addr < 32'd1024);
    led   = !ram && (addr[31:2] == 30'h400);
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    if (!legal || !(ram || led)) begin
      exp_err = 1'b1;
    end else if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          if (ram) mm[addr[9:2]][8*l +: 8] = wd[8*l +: 8];
          else if (l == 0) exp_led[7:0] = wd[7:0];
          else if (l == 1) exp_led[15:8] = wd[15:8];
          else if (l == 2) exp_led[17:16] = wd[17:16];
        end
      end
    end else begin
      exp_rdata = ram ? mm[addr[9:2]] : {14'b0, exp_led};
    end
    exp_valid = 1'b1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (!rst && run_chk) begin
      chk("req_ready", 32'(req_ready), 32'(!exp_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("led_out", 32'(led_out), 32'(exp_led));
      if (exp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
  end

  // One request/response; during a held response a junk store is presented and must be ignored.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      input logic lit_en, input logic [31:0] lit_rd, input logic lit_er);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_busy  = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    if (LAT > 1) #1;
    model_commit(we, addr, wd, be);
    @(negedge clk);
    if (lit_en) begin
      chk("lit_rdata", rsp_rdata, lit_rd);
      chk("lit_err", 32'(rsp_err), 32'(lit_er));
    end
    if (hold > 0) begin
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0; req_be = 4'hF; req_valid = 1'b1;
      repeat (hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Accept a request then pulse reset before the wait-state build would commit it.
  task automatic xact_reset(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (LAT == 1) model_commit(we, addr, wd, be);
    #1 rst = 1'b1;
    #1;
    exp_busy = 1'b0; exp_valid = 1'b0; exp_led = 18'h0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_led_out", 32'(led_out), 32'h0);
    @(negedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    foreach (mm[i]) mm[i] = 32'h0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_led_out", 32'(led_out), 32'h0);
    run_chk = 1'b1;

    // Full-word store and load back.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b1, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    // Lane stores into a zeroed word.
    xact(1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h20, 32'h000000AA, 4'b0001, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h20, 32'h00005500, 4'b0010, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, 32'h000055AA, 1'b0);
    xact(1'b1, 32'h20, 32'h12340000, 4'b1100, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 4'b0001, 0, 1'b1, 32'h123455AA, 1'b0);
    xact(1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h24, 32'h00770000, 4'b0100, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h24, 32'h11000000, 4'b1000, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h24, 32'h00002233, 4'b0011, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b0, 32'h27, 32'h0, 4'b1000, 0, 1'b1, 32'h11772233, 1'b0);
    // LED register: full store, readback, lane-2 and ignored lane-3 stores.
    xact(1'b1, 32'h1000, 32'h0003FFFF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    chk("lit_led_3ffff", 32'(led_out), 32'h3FFFF);
    xact(1'b0, 32'h1000, 32'h0, 4'hF, 0, 1'b1, 32'h0003FFFF, 1'b0);
    xact(1'b1, 32'h1002, 32'hFF020000, 4'b0100, 0, 1'b0, 32'h0, 1'b0);
    chk("lit_led_2ffff", 32'(led_out), 32'h2FFFF);
    xact(1'b1, 32'h1000, 32'hFF000000, 4'b1000, 0, 1'b1, 32'h0, 1'b0);
    // Error cases leave RAM and LED untouched.
    xact(1'b0, 32'h8000, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b1);
    xact(1'b1, 32'h10, 32'h55555555, 4'b0101, 0, 1'b1, 32'h0, 1'b1);
    xact(1'b1, 32'h1000, 32'h0, 4'b0000, 0, 1'b1, 32'h0, 1'b1);
    xact(1'b1, 32'h1000, 32'h0, 4'b0111, 0, 1'b1, 32'h0, 1'b1);
    chk("lit_led_kept", 32'(led_out), 32'h2FFFF);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    // RAM top boundary and first out-of-range word.
    xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b1, 32'h3FC, 32'h11223344, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    xact(1'b0, 32'h3FC, 32'h0, 4'hF, 0, 1'b1, 32'h11223344, 1'b0);
    xact(1'b1, 32'h400, 32'h99999999, 4'hF, 0, 1'b1, 32'h0, 1'b1);
    xact(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1, 32'hA5A5A5A5, 1'b0);
    // Held response with an ignored request pending, then confirm no junk write.
    xact(1'b0, 32'h20, 32'h0, 4'hF, 4, 1'b1, 32'h123455AA, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 2, 1'b1, 32'hDEADBEEF, 1'b0);
    // A req_valid glitch between edges is not accepted.
    @(negedge clk);
    req_valid = 1'b1;
    #2 req_valid = 1'b0;
    @(negedge clk);
    // Reset with a store in flight.
    xact_reset(1'b1, 32'h10, 32'h01020304, 4'hF);
    @(negedge clk);
    chk("post_rst_led", 32'(led_out), 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1, (LAT == 1) ? 32'h01020304 : 32'hDEADBEEF, 1'b0);
    xact(1'b0, 32'h1000, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
